// File: rtl/ex_stage.sv
// Execute stage: ALU, NZCV flag register, conditional jump resolution and a
// 32-step shift-add multiplier that stalls upstream, all feeding the EX/MEM register.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rd_addr_i,
    input  logic        ram_en_i,
    input  logic        ram_rw_i,
    input  logic        J_i,
    input  logic [3:0]  flag_t_i,
    input  logic [3:0]  oprt_i,
    input  logic        wen_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [31:0] ram_ind_i,
    output logic        stall_o,
    output logic [4:0]  rd_addr_o,
    output logic        wen_o,
    output logic        ram_en_o,
    output logic        ram_rw_o,
    output logic [31:0] result_o,
    output logic [31:0] store_data_o,
    output logic        br_taken_o,
    output logic [31:0] br_target_o,
    output logic [3:0]  flags_o
);

    localparam int unsigned XLEN       = 32;
    localparam int unsigned MUL_CYCLES = 32;
    localparam int unsigned CNT_W      = $clog2(MUL_CYCLES);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_SLT = 4'd9;
    localparam logic [3:0] OP_MOV = 4'd10;
    localparam logic [3:0] OP_CMP = 4'd11;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   acc_q, acc_d;

    logic [4:0]        rd_addr_d;
    logic              wen_d, ram_en_d, ram_rw_d, br_taken_d;
    logic [XLEN-1:0]   result_d, store_data_d, br_target_d;
    logic [3:0]        flags_d;

    logic [XLEN:0]     sum;
    logic [XLEN-1:0]   diff;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   flag_res;
    logic              flag_c, flag_v, flag_upd;
    logic              cond_ok;
    logic [XLEN-1:0]   mul_step;

    // Single-cycle ALU and flag candidates
    always_comb begin
        sum  = (XLEN+1)'(op1_i) + (XLEN+1)'(op2_i);
        diff = op1_i - op2_i;
        case (oprt_i)
            OP_ADD:  alu_res = sum[XLEN-1:0];
            OP_SUB:  alu_res = diff;
            OP_AND:  alu_res = op1_i & op2_i;
            OP_OR:   alu_res = op1_i | op2_i;
            OP_XOR:  alu_res = op1_i ^ op2_i;
            OP_SLL:  alu_res = op1_i << op2_i[4:0];
            OP_SRL:  alu_res = op1_i >> op2_i[4:0];
            OP_SRA:  alu_res = XLEN'($signed(op1_i) >>> op2_i[4:0]);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
            OP_MOV:  alu_res = op2_i;
            default: alu_res = '0;
        endcase

        if (oprt_i == OP_ADD) begin
            flag_res = sum[XLEN-1:0];
            flag_c   = sum[XLEN];
            flag_v   = (op1_i[XLEN-1] == op2_i[XLEN-1]) && (sum[XLEN-1] != op1_i[XLEN-1]);
        end else begin
            flag_res = diff;
            flag_c   = (op1_i >= op2_i);
            flag_v   = (op1_i[XLEN-1] != op2_i[XLEN-1]) && (diff[XLEN-1] != op1_i[XLEN-1]);
        end
        flag_upd = (((oprt_i == OP_ADD) || (oprt_i == OP_SUB)) && wen_i) || (oprt_i == OP_CMP);
    end

    // Jump condition against the flags held before this instruction updates them
    always_comb begin
        case (flag_t_i)
            4'd0:    cond_ok = 1'b1;
            4'd1:    cond_ok = flags_o[2];
            4'd2:    cond_ok = !flags_o[2];
            4'd3:    cond_ok = flags_o[3] ^ flags_o[0];
            4'd4:    cond_ok = !(flags_o[3] ^ flags_o[0]);
            4'd5:    cond_ok = flags_o[1];
            4'd6:    cond_ok = !flags_o[1];
            4'd7:    cond_ok = flags_o[3];
            4'd8:    cond_ok = !flags_o[3];
            default: cond_ok = 1'b0;
        endcase
    end

    assign mul_step = mplier_q[0] ? mcand_q : '0;

    // Next-state and EX/MEM next values; sync reset folded in here
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        acc_d        = acc_q;
        flags_d      = flags_o;
        stall_o      = 1'b0;
        rd_addr_d    = '0;
        wen_d        = 1'b0;
        ram_en_d     = 1'b0;
        ram_rw_d     = 1'b0;
        result_d     = '0;
        store_data_d = '0;
        br_taken_d   = 1'b0;
        br_target_d  = '0;

        if (!rst) begin
            state_d  = IDLE;
            count_d  = '0;
            mcand_d  = '0;
            mplier_d = '0;
            acc_d    = '0;
            flags_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (oprt_i == OP_MUL) begin
                        stall_o  = 1'b1;
                        mcand_d  = op1_i;
                        mplier_d = op2_i;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = RUN;
                    end else begin
                        rd_addr_d    = rd_addr_i;
                        wen_d        = wen_i && (oprt_i != OP_CMP);
                        ram_en_d     = ram_en_i;
                        ram_rw_d     = ram_rw_i;
                        result_d     = alu_res;
                        store_data_d = ram_ind_i;
                        br_taken_d   = J_i && cond_ok;
                        br_target_d  = (J_i && cond_ok) ? ram_ind_i : '0;
                        if (flag_upd) begin
                            flags_d = {flag_res[XLEN-1], flag_res == '0, flag_c, flag_v};
                        end
                    end
                end
                RUN: begin
                    if (count_q != CNT_W'(MUL_CYCLES - 1)) begin
                        stall_o  = 1'b1;
                        acc_d    = acc_q + mul_step;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                        count_d  = count_q + CNT_W'(1);
                    end else begin
                        // Last partial product goes straight into the output register
                        result_d     = acc_q + mul_step;
                        rd_addr_d    = rd_addr_i;
                        wen_d        = wen_i;
                        ram_rw_d     = ram_rw_i;
                        store_data_d = ram_ind_i;
                        count_d      = '0;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        count_q      <= count_d;
        mcand_q      <= mcand_d;
        mplier_q     <= mplier_d;
        acc_q        <= acc_d;
        flags_o      <= flags_d;
        rd_addr_o    <= rd_addr_d;
        wen_o        <= wen_d;
        ram_en_o     <= ram_en_d;
        ram_rw_o     <= ram_rw_d;
        result_o     <= result_d;
        store_data_o <= store_data_d;
        br_taken_o   <= br_taken_d;
        br_target_o  <= br_target_d;
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: per-cycle comparison against a behavioural model
// plus hand-computed literal expectations.
module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic [4:0]  rd_addr_i;
    logic        ram_en_i, ram_rw_i, J_i, wen_i;
    logic [3:0]  flag_t_i, oprt_i;
    logic [31:0] op1_i, op2_i, ram_ind_i;
    logic        stall_o, wen_o, ram_en_o, ram_rw_o, br_taken_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] result_o, store_data_o, br_target_o;
    logic [3:0]  flags_o;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .rd_addr_i(rd_addr_i), .ram_en_i(ram_en_i),
        .ram_rw_i(ram_rw_i), .J_i(J_i), .flag_t_i(flag_t_i), .oprt_i(oprt_i),
        .wen_i(wen_i), .op1_i(op1_i), .op2_i(op2_i), .ram_ind_i(ram_ind_i),
        .stall_o(stall_o), .rd_addr_o(rd_addr_o), .wen_o(wen_o),
        .ram_en_o(ram_en_o), .ram_rw_o(ram_rw_o), .result_o(result_o),
        .store_data_o(store_data_o), .br_taken_o(br_taken_o),
        .br_target_o(br_target_o), .flags_o(flags_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_busy = 0;   // edges remaining until the product is written
    logic [31:0] m_prod;
    logic [4:0]  e_rd = 0;
    logic        e_wen = 0, e_ren = 0, e_rw = 0, e_br = 0;
    logic [31:0] e_res = 0, e_store = 0, e_tgt = 0;
    logic [3:0]  e_flags = 0;

    function automatic logic cond(input logic [3:0] ft, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (ft)
            0: return 1'b1;
            1: return z;
            2: return !z;
            3: return n ^ v;
            4: return !(n ^ v);
            5: return c;
            6: return !c;
            7: return n;
            8: return !n;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << b[4:0];
            6: return a >> b[4:0];
            7: return 32'(sa >>> b[4:0]);
            9: return (sa < sb) ? 32'd1 : 32'd0;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic bubble_out();
        e_rd = 0; e_wen = 0; e_ren = 0; e_rw = 0; e_br = 0;
        e_res = 0; e_store = 0; e_tgt = 0;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 0;
            e_flags = 0;
            bubble_out();
        end else if (m_busy == 0 && oprt_i == 4'd8) begin
            m_busy = 32;
            m_prod = op1_i * op2_i;
            bubble_out();
        end else if (m_busy > 1) begin
            m_busy--;
            bubble_out();
        end else if (m_busy == 1) begin
            m_busy = 0;
            bubble_out();
            e_res = m_prod; e_rd = rd_addr_i; e_wen = wen_i;
            e_rw = ram_rw_i; e_store = ram_ind_i;
        end else begin
            logic taken;
            logic [63:0] u;
            longint s;
            logic [31:0] r;
            taken = J_i && cond(flag_t_i, e_flags);
            e_rd = rd_addr_i; e_wen = wen_i && (oprt_i != 4'd11);
            e_ren = ram_en_i; e_rw = ram_rw_i; e_store = ram_ind_i;
            e_res = alu(oprt_i, op1_i, op2_i);
            e_br = taken; e_tgt = taken ? ram_ind_i : 32'd0;
            if (oprt_i == 4'd0 && wen_i) begin
                u = 64'(op1_i) + 64'(op2_i);
                s = longint'($signed(op1_i)) + longint'($signed(op2_i));
                r = u[31:0];
                e_flags = {r[31], r == 0, u[32], (s > 64'sd2147483647) || (s < -64'sd2147483648)};
            end else if ((oprt_i == 4'd1 && wen_i) || oprt_i == 4'd11) begin
                s = longint'($signed(op1_i)) - longint'($signed(op2_i));
                r = op1_i - op2_i;
                e_flags = {r[31], r == 0, op1_i >= op2_i, (s > 64'sd2147483647) || (s < -64'sd2147483648)};
            end
        end
    end

    // Per-cycle compare, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            logic e_stall;
            e_stall = rst && ((m_busy == 0 && oprt_i == 4'd8) || m_busy > 1);
            chk("stall_o", 32'(stall_o), 32'(e_stall));
            chk("rd_addr_o", 32'(rd_addr_o), 32'(e_rd));
            chk("wen_o", 32'(wen_o), 32'(e_wen));
            chk("ram_en_o", 32'(ram_en_o), 32'(e_ren));
            chk("ram_rw_o", 32'(ram_rw_o), 32'(e_rw));
            chk("result_o", result_o, e_res);
            chk("store_data_o", store_data_o, e_store);
            chk("br_taken_o", 32'(br_taken_o), 32'(e_br));
            chk("br_target_o", br_target_o, e_tgt);
            chk("flags_o", 32'(flags_o), 32'(e_flags));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic w, input logic [4:0] rd, input logic [31:0] ind = 0,
                          input logic j = 0, input logic [3:0] ft = 0,
                          input logic ren = 0, input logic rrw = 0);
        oprt_i = op; op1_i = a; op2_i = b; wen_i = w; rd_addr_i = rd;
        ram_ind_i = ind; J_i = j; flag_t_i = ft; ram_en_i = ren; ram_rw_i = rrw;
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] prod);
        set_in(4'd8, a, b, 1'b1, rd);
        #1;
        for (int i = 0; i < 32; i++) begin
            chk("mul stall high", 32'(stall_o), 32'd1);
            tick();
            chk("mul bubble wen", 32'(wen_o), 32'd0);
        end
        chk("mul stall released", 32'(stall_o), 32'd0);
        tick();
        chk("mul product", result_o, prod);
        chk("mul rd", 32'(rd_addr_o), 32'(rd));
        chk("mul wen", 32'(wen_o), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        set_in(4'd0, 0, 0, 1'b0, 5'd0);
        tick();
        check_en = 1'b1;
        tick();
        chk("reset result", result_o, 32'd0);
        chk("reset flags", 32'(flags_o), 32'd0);
        chk("reset stall", 32'(stall_o), 32'd0);
        chk("reset wen", 32'(wen_o), 32'd0);
        rst = 1'b1;

        set_in(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, 5'd5);
        tick();
        chk("add ovf result", result_o, 32'h8000_0000);
        chk("add ovf flags", 32'(flags_o), 32'b1001);
        chk("add rd", 32'(rd_addr_o), 32'd5);

        set_in(4'd11, 32'd5, 32'd5, 1'b1, 5'd7);
        tick();
        chk("cmp flags", 32'(flags_o), 32'b0110);
        chk("cmp wen", 32'(wen_o), 32'd0);

        set_in(4'd0, 0, 0, 1'b0, 5'd0, 32'h40, 1'b1, 4'd1);
        tick();
        chk("jeq taken", 32'(br_taken_o), 32'd1);
        chk("jeq target", br_target_o, 32'h40);
        set_in(4'd0, 0, 0, 1'b0, 5'd0);
        tick();
        chk("jeq pulse end", 32'(br_taken_o), 32'd0);
        chk("jeq target clr", br_target_o, 32'd0);

        set_in(4'd0, 0, 0, 1'b1, 5'd1);
        tick();
        chk("zero add flags", 32'(flags_o), 32'b0100);
        set_in(4'd0, 0, 0, 1'b0, 5'd0);
        tick();
        chk("bubble flags", 32'(flags_o), 32'b0100);
        chk("bubble wen", 32'(wen_o), 32'd0);

        set_in(4'd0, 0, 0, 1'b0, 5'd0, 32'h80, 1'b1, 4'd2);
        tick();
        chk("jne not taken", 32'(br_taken_o), 32'd0);
        set_in(4'd0, 0, 0, 1'b0, 5'd0, 32'h80, 1'b1, 4'd9);
        tick();
        chk("never cond", 32'(br_taken_o), 32'd0);

        set_in(4'd0, 32'h100, 32'd8, 1'b0, 5'd0, 32'hDEAD, 1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        chk("store addr", result_o, 32'h108);
        chk("store data", store_data_o, 32'hDEAD);
        chk("store rw", 32'(ram_rw_o), 32'd1);
        chk("store en", 32'(ram_en_o), 32'd1);

        set_in(4'd1, 32'd3, 32'd5, 1'b1, 5'd2);
        tick();
        chk("sub neg flags", 32'(flags_o), 32'b1000);
        set_in(4'd7, 32'h8000_0000, 32'd4, 1'b1, 5'd2);
        tick();
        chk("sra", result_o, 32'hF800_0000);
        set_in(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd2);
        tick();
        chk("slt", result_o, 32'd1);
        set_in(4'd5, 32'h0000_00F1, 32'd36, 1'b1, 5'd2);
        tick();
        chk("sll mod32", result_o, 32'h0000_0F10);
        set_in(4'd6, 32'hF000_0000, 32'd8, 1'b1, 5'd2);
        tick();
        set_in(4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 5'd2);
        tick();
        set_in(4'd3, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 5'd2);
        tick();
        set_in(4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 5'd2);
        tick();
        chk("xor", result_o, 32'hF0F0_F0F0);
        set_in(4'd10, 32'd1, 32'h1234_5678, 1'b1, 5'd6);
        tick();
        set_in(4'd13, 32'd1, 32'd2, 1'b1, 5'd6);
        tick();
        chk("undef op", result_o, 32'd0);
        set_in(4'd1, 32'h8000_0000, 32'd1, 1'b1, 5'd2);
        tick();
        chk("sub ovf flags", 32'(flags_o), 32'b0011);
        set_in(4'd0, 0, 0, 1'b0, 5'd0, 32'h200, 1'b1, 4'd3);
        tick();
        chk("jlt taken", 32'(br_taken_o), 32'd1);
        set_in(4'd0, 32'h8000_0000, 32'h8000_0000, 1'b1, 5'd2);
        tick();
        chk("add carry flags", 32'(flags_o), 32'b0111);

        run_mul(32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB);
        run_mul(32'd3, 32'd4, 5'd4, 32'd12);
        set_in(4'd0, 0, 0, 1'b0, 5'd0);
        tick();
        chk("mul wen pulse", 32'(wen_o), 32'd0);

        set_in(4'd8, 32'd5, 32'd6, 1'b1, 5'd9);
        tick();
        repeat (10) tick();
        rst = 1'b0;
        #1;
        chk("reset stall", 32'(stall_o), 32'd0);
        tick();
        chk("rst mid-mul result", result_o, 32'd0);
        chk("rst mid-mul wen", 32'(wen_o), 32'd0);
        chk("rst mid-mul flags", 32'(flags_o), 32'd0);
        rst = 1'b1;
        set_in(4'd0, 32'd2, 32'd2, 1'b1, 5'd2);
        #1;
        chk("post-rst no stall", 32'(stall_o), 32'd0);
        tick();
        chk("post-rst add", result_o, 32'd4);

        set_in(4'd0, 0, 0, 1'b0, 5'd0);
        tick();
        tick();
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage core; sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Performs ALU operations, holds the NZCV flag register, resolves conditional jumps, and runs an iterative 32-cycle multiplier that stalls upstream stages.
- All results are captured into an internal EX/MEM register that feeds the memory stage.

Parameters:
- MUL_CYCLES, 32, multiplier iterations; fixed, not user-tunable, one result bit per iteration.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- rd_addr_i  in  5  destination register
- ram_en_i  in  1  memory access enable
- ram_rw_i  in  1  1 = store, 0 = load
- J_i  in  1  jump instruction
- flag_t_i  in  4  jump condition code
- oprt_i  in  4  ALU opcode
- wen_i  in  1  register write enable
- op1_i  in  32  operand 1
- op2_i  in  32  operand 2
- ram_ind_i  in  32  store data; jump target when J_i=1
- stall_o  out  1  combinational; ID/EX and earlier stages freeze while 1
- rd_addr_o  out  5  registered
- wen_o  out  1  registered
- ram_en_o  out  1  registered
- ram_rw_o  out  1  registered
- result_o  out  32  registered ALU result / memory address
- store_data_o  out  32  registered ram_ind_i
- br_taken_o  out  1  registered, one-cycle pulse
- br_target_o  out  32  registered jump target
- flags_o  out  4  NZCV register {N,Z,C,V}

Behaviour:
- Reset (rst=0 at posedge): all registered outputs 0, flags 0000, FSM to IDLE, multiplier counter 0. Reset takes priority over everything, including a multiply in flight (result discarded). stall_o=0 while in reset.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount op2_i[4:0].
  - 8 MUL (low 32 bits, result identical for signed or unsigned operands).
  - 9 SLT (signed; result 1 or 0).
  - 10 MOV (result=op2_i).
  - 11 CMP (SUB; result discarded; wen_o forced 0).
  - 12-15: result 0.
- Flags:
  - Update only for ADD/SUB when wen_i=1, or for CMP regardless of wen_i. No other opcode changes flags; an all-zero bubble (ADD, wen=0) leaves flags unchanged.
  - N = result[31]. Z = (result==0).
  - ADD: C = carry out of bit 31. SUB/CMP: C = 1 when op1 >= op2 unsigned (no borrow).
  - V = signed overflow.
- Jump conditions (flag_t_i), evaluated against the current flag register before this instruction's own update:
  - 0 always, 1 EQ (Z), 2 NE (!Z), 3 LT (N^V), 4 GE (!(N^V)), 5 CS (C), 6 CC (!C), 7 MI (N), 8 PL (!N).
  - 9-15 never.
- br_taken_o = J_i & cond; br_target_o = ram_ind_i when taken, else 0. Upstream flushes on br_taken_o; ex_stage itself does not flush.
- Single-cycle ops: one-cycle latency; every output register loads at the edge ending the cycle the inputs are presented.
- store_data_o = ram_ind_i. rd_addr, wen, ram_en and ram_rw pass through (wen forced 0 for CMP).
- Multiply FSM: IDLE, RUN.
  - IDLE with oprt_i=8: stall_o=1. At the edge, latch multiplicand/multiplier, clear accumulator, count=0, go to RUN. Output registers load a bubble (wen/ram_en/br_taken = 0; others 0).
  - RUN: one shift-add step per cycle. stall_o=1 while count<31, and output registers keep loading bubbles.
  - RUN at count=31: stall_o=0. The final add is folded into the output register write: result_o gets the product, with rd_addr/wen from the still-held inputs. Then return to IDLE.
  - Timing: stall_o is high for exactly 32 cycles, and the product appears 33 edges after MUL is first presented.
  - A MUL immediately following a MUL restarts from IDLE normally.
  - J_i and ram_en_i are 0 for MUL by decode contract; they are ignored while in RUN.
- Arithmetic is 32-bit wrap-around; no exceptions.

Test Plan:
- ADD 0x7FFFFFFF+1, wen=1 -> result_o=0x80000000 next cycle; flags N=1,Z=0,C=0,V=1.
- CMP 5,5 then J with flag_t=1, ram_ind=0x40 -> flags Z=1,C=1; br_taken_o=1 for exactly one cycle, br_target_o=0x40; wen_o=0 for CMP.
- Bubble (all inputs 0) after flags=0100 -> flags stay 0100, wen_o=0.
- MUL 7 x 0xFFFFFFFD, wen=1, rd=3 -> stall_o high for 32 cycles with wen_o=0 throughout; then result_o=0xFFFFFFEB, rd_addr_o=3, wen_o=1 for one cycle; back-to-back MUL 3x4 -> second stall window, then result 12.
- rst=0 at RUN count=10 -> next cycle all outputs 0, stall_o=0, FSM IDLE; a following ADD 2+2 gives result_o=4 in one cycle.
- Store: ram_en=1, ram_rw=1, ADD op1=0x100, op2=8, ram_ind=0xDEAD -> result_o=0x108, store_data_o=0xDEAD, ram_rw_o=1.
